// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and default parameters for game_flow_ctl
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        HOLD_WIN  = 3'd2,
        HOLD_LOSS = 3'd3,
        OVER      = 3'd4
    } state_t;

    localparam int LIVES_DEFAULT       = 3;
    localparam int HOLD_FRAMES_DEFAULT = 60;

endpackage

// File: rtl/edge_rise.sv
// rtl/edge_rise.sv - single-bit rising edge detector (history register plus AND-NOT)
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= din;
        end
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/game_flow_ctl.sv
// rtl/game_flow_ctl.sv - game flow FSM: play, win/loss hold, lives and game over
module game_flow_ctl
    import game_pkg::*;
#(
    parameter int LIVES       = LIVES_DEFAULT,
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       goal_reached,
    input  logic       player_collision,
    input  logic       time_out,
    input  logic       vsync_in,
    output logic       restart,
    output logic       level_up,
    output logic       freeze,
    output logic [1:0] lives,
    output logic       game_over,
    output logic [2:0] state
);

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);

    state_t     state_q, state_n;
    logic [1:0] lives_n;
    logic [7:0] cnt_q, cnt_n;
    logic       restart_n, level_up_n;
    logic       armed;
    logic       goal_raw, coll_raw, to_raw, vs_raw;
    logic       goal_e, coll_e, to_e, vs_e;

    edge_rise u_edge_goal (.clk(clk), .rst(rst), .din(goal_reached),     .rise(goal_raw));
    edge_rise u_edge_coll (.clk(clk), .rst(rst), .din(player_collision), .rise(coll_raw));
    edge_rise u_edge_to   (.clk(clk), .rst(rst), .din(time_out),         .rise(to_raw));
    edge_rise u_edge_vs   (.clk(clk), .rst(rst), .din(vsync_in),         .rise(vs_raw));

    // History is zero out of reset, so the first cycle only primes it; inputs
    // already high at release must not look like fresh events.
    assign goal_e = goal_raw & armed;
    assign coll_e = coll_raw & armed;
    assign to_e   = to_raw   & armed;
    assign vs_e   = vs_raw   & armed;

    always_comb begin
        state_n    = state_q;
        lives_n    = lives;
        cnt_n      = cnt_q;
        restart_n  = 1'b0;
        level_up_n = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_n   = PLAY;
                    lives_n   = LIVES_INIT;
                    restart_n = 1'b1;
                end
            end
            PLAY: begin
                if (goal_e) begin
                    state_n = HOLD_WIN;
                    cnt_n   = 8'd0;
                end else if (coll_e || to_e) begin
                    state_n = HOLD_LOSS;
                    cnt_n   = 8'd0;
                    lives_n = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                end
            end
            HOLD_WIN, HOLD_LOSS: begin
                if (vs_e) begin
                    if (cnt_q == HOLD_LAST) begin
                        if (state_q == HOLD_WIN) begin
                            state_n    = PLAY;
                            restart_n  = 1'b1;
                            level_up_n = 1'b1;
                        end else if (lives != 2'd0) begin
                            state_n   = PLAY;
                            restart_n = 1'b1;
                        end else begin
                            state_n = OVER;
                        end
                    end else if (cnt_q != 8'hFF) begin
                        cnt_n = cnt_q + 8'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lives     <= LIVES_INIT;
            cnt_q     <= 8'd0;
            restart   <= 1'b0;
            level_up  <= 1'b0;
            freeze    <= 1'b1;
            game_over <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state_q   <= state_n;
            lives     <= lives_n;
            cnt_q     <= cnt_n;
            restart   <= restart_n;
            level_up  <= level_up_n;
            freeze    <= (state_n != PLAY);
            game_over <= (state_n == OVER);
            armed     <= 1'b1;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_game_flow_ctl.sv
// tb/tb_game_flow_ctl.sv - scoreboard bench for game_flow_ctl with LIVES=3, HOLD_FRAMES=2
module tb_game_flow_ctl;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PLAY = 3'd1;
    localparam logic [2:0] S_HW   = 3'd2;
    localparam logic [2:0] S_HL   = 3'd3;
    localparam logic [2:0] S_OVER = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, goal_reached, player_collision, time_out, vsync_in;
    logic       restart, level_up, freeze, game_over;
    logic [1:0] lives;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    game_flow_ctl #(.LIVES(3), .HOLD_FRAMES(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .goal_reached     (goal_reached),
        .player_collision (player_collision),
        .time_out         (time_out),
        .vsync_in         (vsync_in),
        .restart          (restart),
        .level_up         (level_up),
        .freeze           (freeze),
        .lives            (lives),
        .game_over        (game_over),
        .state            (state)
    );

    // Observed tuple: {state, lives, freeze, restart, level_up, game_over}
    logic [8:0] obs;
    assign obs = {state, lives, freeze, restart, level_up, game_over};

    function automatic logic [8:0] mk(input logic [2:0] st, input logic [1:0] lv,
                                      input logic fr, input logic rs,
                                      input logic lu, input logic go);
        return {st, lv, fr, rs, lu, go};
    endfunction

    task automatic expect_obs(input string tag, input logic [8:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
    endtask

    task automatic pulse_ev(input logic [2:0] v);
        {goal_reached, player_collision, time_out} = v;
        cyc();
        {goal_reached, player_collision, time_out} = 3'b000;
        cyc();
    endtask

    task automatic pulse_vsync(input int n);
        for (int i = 0; i < n; i++) begin
            vsync_in = 1'b1;
            cyc();
            vsync_in = 1'b0;
            cyc();
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: %0d expected responses never seen, next wanted %h",
                     tag, exp_q.size(), exp_q[0]);
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    // Monitor: every change of the observed tuple must match the queue head.
    initial begin
        logic [8:0] prev_obs;
        logic [8:0] want;
        string      tag;
        prev_obs = 9'h1FF;
        forever begin
            @(negedge clk);
            if (obs !== prev_obs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %h after %h, none required", obs, prev_obs);
                end else begin
                    want = exp_q.pop_front();
                    tag  = tag_q.pop_front();
                    if (obs !== want) begin
                        errors++;
                        $display("FAIL %s: got %h required %h", tag, obs, want);
                    end
                end
                prev_obs = obs;
            end
        end
    end

    initial begin
        rst = 1'b1;
        {start, goal_reached, player_collision, time_out, vsync_in} = 5'b0;
        expect_obs("reset", mk(S_IDLE, 2'd3, 1, 0, 0, 0));
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        wait_drain("reset");

        expect_obs("start_pulse", mk(S_PLAY, 2'd3, 0, 1, 0, 0));
        expect_obs("start_play",  mk(S_PLAY, 2'd3, 0, 0, 0, 0));
        do_start();
        wait_drain("start");

        expect_obs("goal_hold",   mk(S_HW,   2'd3, 1, 0, 0, 0));
        expect_obs("goal_pulse",  mk(S_PLAY, 2'd3, 0, 1, 1, 0));
        expect_obs("goal_play",   mk(S_PLAY, 2'd3, 0, 0, 0, 0));
        pulse_ev(3'b100);
        pulse_vsync(2);
        wait_drain("goal");

        expect_obs("goalcoll_hold",  mk(S_HW,   2'd3, 1, 0, 0, 0));
        expect_obs("goalcoll_pulse", mk(S_PLAY, 2'd3, 0, 1, 1, 0));
        expect_obs("goalcoll_play",  mk(S_PLAY, 2'd3, 0, 0, 0, 0));
        pulse_ev(3'b110);
        pulse_vsync(2);
        wait_drain("goalcoll");

        expect_obs("coll1_hold",  mk(S_HL,   2'd2, 1, 0, 0, 0));
        expect_obs("coll1_pulse", mk(S_PLAY, 2'd2, 0, 1, 0, 0));
        expect_obs("coll1_play",  mk(S_PLAY, 2'd2, 0, 0, 0, 0));
        pulse_ev(3'b010);
        pulse_vsync(2);
        expect_obs("coll2_hold",  mk(S_HL,   2'd1, 1, 0, 0, 0));
        expect_obs("coll2_pulse", mk(S_PLAY, 2'd1, 0, 1, 0, 0));
        expect_obs("coll2_play",  mk(S_PLAY, 2'd1, 0, 0, 0, 0));
        pulse_ev(3'b010);
        pulse_vsync(2);
        expect_obs("coll3_hold",  mk(S_HL,   2'd0, 1, 0, 0, 0));
        expect_obs("coll3_over",  mk(S_OVER, 2'd0, 1, 0, 0, 1));
        pulse_ev(3'b010);
        pulse_vsync(2);
        wait_drain("three_coll");
        pulse_vsync(2);

        expect_obs("restart_pulse", mk(S_PLAY, 2'd3, 0, 1, 0, 0));
        expect_obs("restart_play",  mk(S_PLAY, 2'd3, 0, 0, 0, 0));
        do_start();
        wait_drain("restart_from_over");

        // time_out held across ten frames must cost exactly one life
        expect_obs("to_hold",  mk(S_HL,   2'd2, 1, 0, 0, 0));
        expect_obs("to_pulse", mk(S_PLAY, 2'd2, 0, 1, 0, 0));
        expect_obs("to_play",  mk(S_PLAY, 2'd2, 0, 0, 0, 0));
        time_out = 1'b1;
        cyc();
        pulse_vsync(10);
        time_out = 1'b0;
        cyc();
        wait_drain("time_out_held");

        expect_obs("collto_hold",  mk(S_HL,   2'd1, 1, 0, 0, 0));
        expect_obs("collto_pulse", mk(S_PLAY, 2'd1, 0, 1, 0, 0));
        expect_obs("collto_play",  mk(S_PLAY, 2'd1, 0, 0, 0, 0));
        pulse_ev(3'b011);
        pulse_vsync(2);
        wait_drain("coll_and_to");

        // Events during a hold are ignored; last life lost leads to OVER
        expect_obs("last_hold", mk(S_HL,   2'd0, 1, 0, 0, 0));
        expect_obs("last_over", mk(S_OVER, 2'd0, 1, 0, 0, 1));
        pulse_ev(3'b010);
        pulse_ev(3'b100);
        pulse_ev(3'b011);
        pulse_vsync(2);
        wait_drain("ignore_in_hold");

        expect_obs("again_pulse", mk(S_PLAY, 2'd3, 0, 1, 0, 0));
        expect_obs("again_play",  mk(S_PLAY, 2'd3, 0, 0, 0, 0));
        do_start();
        wait_drain("start_again");

        expect_obs("rsthold_hold", mk(S_HL,   2'd2, 1, 0, 0, 0));
        expect_obs("rsthold_idle", mk(S_IDLE, 2'd3, 1, 0, 0, 0));
        pulse_ev(3'b010);
        pulse_vsync(1);
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        pulse_vsync(3);
        wait_drain("reset_mid_hold");

        expect_obs("post_rst_pulse", mk(S_PLAY, 2'd3, 0, 1, 0, 0));
        expect_obs("post_rst_play",  mk(S_PLAY, 2'd3, 0, 0, 0, 0));
        do_start();
        wait_drain("post_reset_start");
        repeat (5) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_flow_ctl.md
GAME_FLOW_CTL -- requirements
Module: game_flow_ctl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clk and rst.
REQ-002 Parameter LIVES, default 3: lives loaded at game start, range 1..3.
REQ-003 Parameter HOLD_FRAMES, default 60: frames frozen after a win or loss, range 1..255.
REQ-004 clk  in  1  game clock (100 MHz domain).
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  player start request, level-sensitive, synchronous to clk.
REQ-007 goal_reached  in  1  goal event from the level manager; level or pulse.
REQ-008 player_collision  in  1  hero-enemy contact; level or pulse.
REQ-009 time_out  in  1  timer expiry; level or pulse.
REQ-010 vsync_in  in  1  frame sync, already synchronised to clk.
REQ-011 restart  out  1  one-cycle pulse that resets hero, enemy and map state.
REQ-012 level_up  out  1  one-cycle pulse that advances the level.
REQ-013 freeze  out  1  holds hero and enemy motion while high.
REQ-014 lives  out  2  remaining lives.
REQ-015 game_over  out  1  high in state OVER.
REQ-016 state  out  3  current FSM state for debug.

Function
REQ-017 The block SHALL register all outputs; no output SHALL depend combinationally on an input.
REQ-018 It SHALL rising-edge-detect goal_reached, player_collision, time_out and vsync_in internally; a held-high input SHALL count as one event.
REQ-019 FSM states: IDLE, PLAY, HOLD_WIN, HOLD_LOSS, OVER.
REQ-020 IDLE: freeze=1; start=1 -> PLAY, lives<=LIVES, restart=1 on the next cycle.
REQ-021 PLAY: freeze=0; a goal edge -> HOLD_WIN; a collision or time_out edge -> HOLD_LOSS with lives<=lives-1.
REQ-022 Simultaneous events in PLAY: goal wins over collision, collision wins over time_out, and at most one life is lost per cycle.
REQ-023 HOLD_WIN/HOLD_LOSS: freeze=1; the frame counter clears on entry and counts vsync rising edges; all event edges are ignored.
REQ-024 When the frame counter reaches HOLD_FRAMES:
- HOLD_WIN -> PLAY; restart=1 and level_up=1 in the same cycle.
- HOLD_LOSS with lives!=0 -> PLAY with restart=1.
- HOLD_LOSS with lives==0 -> OVER, with no restart.
REQ-025 OVER: freeze=1, game_over=1; start=1 -> PLAY, lives<=LIVES, restart=1.
REQ-026 restart and level_up SHALL be high for exactly one clk cycle, the first cycle in PLAY.
REQ-027 lives SHALL saturate at 0 and never wrap.
REQ-028 The frame counter SHALL be 8 bits and SHALL NOT wrap within a hold.

Reset
REQ-029 On rst (asynchronous), the block SHALL enter IDLE with: lives=LIVES, freeze=1, restart=0, level_up=0, game_over=0, counter=0, and edge-detector history=0.
REQ-030 Asserting rst mid-hold SHALL abandon the hold; no restart or level_up pulse SHALL follow.
REQ-031 The first cycle after reset release SHALL NOT produce a false edge, even if inputs are already high.

Structure
REQ-032 Package game_pkg SHALL hold the state enumeration (3-bit encoding) and the LIVES/HOLD_FRAMES defaults.
REQ-033 A sub-module edge_rise (1-bit register plus AND-NOT) SHALL be instantiated four times.

Verification (LIVES=3, HOLD_FRAMES=2)
REQ-034 Reset, then start=1 -> lives=3, restart high for 1 cycle, state=PLAY, freeze=0.
REQ-035 Goal edge in PLAY -> freeze=1; after 2 vsync edges restart=1 and level_up=1 for 1 cycle; lives stay 3.
REQ-036 Goal and collision in the same cycle -> HOLD_WIN; lives unchanged.
REQ-037 Three collisions, each after its hold completes -> lives 2,1,0; after the third hold, state=OVER, game_over=1, no restart; then start -> lives=3, restart pulse.
REQ-038 time_out held high for 10 frames -> exactly one life lost.
REQ-039 rst asserted after 1 vsync in HOLD_LOSS -> immediately IDLE, lives=3, no pulses afterwards.
